// File: rtl/sig_replay_if.sv
// Sample stream bundle for sig_replay: record-side input and playback-side
// valid/ready output. The slave modport is the buffer, the master its environment.
interface sig_replay_if #(
  parameter int D_WIDTH = 8
);
  logic               in_valid;
  logic [D_WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/sig_replay.sv
// Record-then-playback sample buffer: captures a burst into a dual-port RAM,
// then streams it back once or looped over a valid/ready port.
module sig_replay #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_start,
  input  logic             play_start,
  input  logic             stop,
  input  logic             loop,
  sig_replay_if.slave      bus,
  output logic [A_WIDTH:0] length,
  output logic             full,
  output logic [1:0]       state
);

  localparam int                 DEPTH    = 1 << A_WIDTH;
  localparam int                 LEN_W    = A_WIDTH + 1;
  localparam logic [A_WIDTH:0]   LEN_LAST = LEN_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]     length_q, length_d;
  logic                 full_q, full_d;
  logic                 loop_q, loop_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [D_WIDTH-1:0]   rd_data_q;
  logic                 mem_we;
  logic                 rd_en;
  logic                 fetch_last;

  logic [D_WIDTH-1:0]   mem [DEPTH];

  // rd_ptr_q always names the next sample to load into the output register.
  assign fetch_last = ({1'b0, rd_ptr_q} == (length_q - 1'b1));

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    length_d    = length_q;
    full_d      = full_q;
    loop_d      = loop_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          state_d  = ST_RECORD;
          wr_ptr_d = '0;
          length_d = '0;
          full_d   = 1'b0;
        end else if (play_start && (length_q != '0)) begin
          state_d    = ST_PLAY;
          rd_ptr_d   = '0;
          loop_d     = loop;
          out_last_d = 1'b0;
        end
      end

      ST_RECORD: begin
        if (bus.in_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          length_d = length_q + 1'b1;
          if (length_q == LEN_LAST) begin
            state_d = ST_IDLE;
            full_d  = 1'b1;
          end
        end
        if (stop) state_d = ST_IDLE;
      end

      ST_PLAY: begin
        if (stop) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else if (out_valid_q && bus.out_ready && out_last_q && !loop_q) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
          // Refill whenever the output slot empties, so ready=1 streams bubble-free.
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = fetch_last;
          rd_ptr_d    = fetch_last ? '0 : rd_ptr_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      length_q    <= '0;
      full_q      <= 1'b0;
      loop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      length_q    <= length_d;
      full_q      <= full_d;
      loop_q      <= loop_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; length gates reads.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= bus.in_data;
  end

  // Registered read port doubles as the output register and holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rd_data_q;
  assign length        = length_q;
  assign full          = full_q;
  assign state         = state_q;

endmodule

// File: tb/tb_sig_replay.sv
// Directed bench for sig_replay: a vector table for the main record/play flow,
// hand sequences for backpressure, priority, full-buffer and mid-play reset.
module tb_sig_replay;

  localparam int AW  = 9;
  localparam int AWS = 3;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst, rst_s;
  always #5 clk = ~clk;

  logic rec_start, play_start, stop, loop;
  logic rec_start_s, play_start_s, stop_s, loop_s;
  logic [AW:0]  length;
  logic [AWS:0] length_s;
  logic         full, full_s;
  logic [1:0]   state, state_s;

  sig_replay_if #(.D_WIDTH(DW)) bus ();
  sig_replay_if #(.D_WIDTH(DW)) bus_s ();

  sig_replay #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .loop(loop), .bus(bus), .length(length), .full(full), .state(state)
  );

  sig_replay #(.A_WIDTH(AWS), .D_WIDTH(DW)) dut_s (
    .clk(clk), .rst(rst_s), .rec_start(rec_start_s), .play_start(play_start_s),
    .stop(stop_s), .loop(loop_s), .bus(bus_s), .length(length_s), .full(full_s),
    .state(state_s)
  );

  typedef struct {
    logic       rs, ps, sp, lp, iv;
    logic [7:0] id;
    logic       ordy;
    logic [1:0] st;
    logic       ov;
    logic [7:0] od;
    logic [9:0] len;
    logic       fl;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rs, ps, sp, lp, iv, input logic [7:0] id, input logic ordy,
                     input logic [1:0] st, input logic ov, input logic [7:0] od,
                     input logic [9:0] len, input logic fl);
    vec_t v;
    v.rs = rs; v.ps = ps; v.sp = sp; v.lp = lp; v.iv = iv; v.id = id; v.ordy = ordy;
    v.st = st; v.ov = ov; v.od = od; v.len = len; v.fl = fl;
    vq.push_back(v);
  endtask

  function automatic logic [63:0] pack_big();
    return {42'd0, state, bus.out_valid, bus.out_data, length, full};
  endfunction

  logic [7:0] seq [5];

  initial begin
    seq[0] = 8'd10; seq[1] = 8'd20; seq[2] = 8'd30; seq[3] = 8'd40; seq[4] = 8'd50;

    rst = 1'b0; rst_s = 1'b0;
    rec_start = 0; play_start = 0; stop = 0; loop = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    rec_start_s = 0; play_start_s = 0; stop_s = 0; loop_s = 0;
    bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.out_ready = 0;
    #12;
    check("reset_big", pack_big(), 64'd0);
    check("reset_small", {state_s, bus_s.out_valid, bus_s.out_data, length_s, full_s}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; rst_s = 1'b1;

    // play on an empty buffer is ignored
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    // record 10..50 then stop
    add(1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, 1, 8'(k * 10), 0, 2'd1, 0, 0, 10'(k), 0);
    add(0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 5, 0);
    // single play, ready held high
    add(0, 1, 0, 0, 0, 0, 1, 2'd2, 0, 0, 5, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 1, 2'd2, 1, seq[k], 5, 0);
    add(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 50, 5, 0);
    add(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 50, 5, 0);
    // looped play across the wrap, with ignored rec_start and in_valid, then stop
    add(0, 1, 0, 1, 0, 0, 1, 2'd2, 0, 50, 5, 0);
    for (int i = 0; i < 12; i++)
      add(i == 4, i == 7, 0, 0, i == 6, 8'd99, 1, 2'd2, 1, seq[i % 5], 5, 0);
    add(0, 0, 1, 0, 0, 0, 1, 2'd0, 0, 20, 5, 0);

    foreach (vq[i]) begin
      rec_start = vq[i].rs; play_start = vq[i].ps; stop = vq[i].sp; loop = vq[i].lp;
      bus.in_valid = vq[i].iv; bus.in_data = vq[i].id; bus.out_ready = vq[i].ordy;
      tick();
      check($sformatf("vec%0d", i), pack_big(),
            {42'd0, vq[i].st, vq[i].ov, vq[i].od, vq[i].len, vq[i].fl});
    end
    rec_start = 0; play_start = 0; stop = 0; loop = 0; bus.in_valid = 0; bus.out_ready = 0;

    // backpressure: ready pattern 1,0,0,1 repeating
    begin
      logic [3:0] pat;
      int k;
      int cyc;
      pat = 4'b1001; k = 0; cyc = 0;
      play_start = 1; loop = 0;
      tick();
      play_start = 0;
      check("bp_state", state, 2'd2);
      while (state == 2'd2 && cyc < 40) begin
        bus.out_ready = pat[cyc % 4];
        if (bus.out_valid) begin
          if (k < 5) check($sformatf("bp_data%0d", k), bus.out_data, seq[k]);
          else       check("bp_extra_valid", bus.out_valid, 1'b0);
          if (bus.out_ready) k++;
        end
        tick();
        cyc++;
      end
      check("bp_count", k, 5);
      check("bp_end_valid", bus.out_valid, 1'b0);
      check("bp_in_budget", cyc < 40, 1'b1);
      bus.out_ready = 0;
    end

    // rec_start beats play_start; stop in the record cycle still writes
    rec_start = 1; play_start = 1;
    tick();
    rec_start = 0; play_start = 0;
    check("prio_state_len", {state, length}, {2'd1, 10'd0});
    bus.in_valid = 1; bus.in_data = 8'd77; stop = 1;
    tick();
    bus.in_valid = 0; stop = 0;
    check("stop_write", {state, length}, {2'd0, 10'd1});
    play_start = 1; bus.out_ready = 0;
    tick(); play_start = 0;
    tick();
    check("stop_write_data", {bus.out_valid, bus.out_data}, {1'b1, 8'd77});
    stop = 1;
    tick(); stop = 0;
    check("stop_play", {state, bus.out_valid}, {2'd0, 1'b0});

    // small buffer: overflow, auto-IDLE, playback, mid-play reset
    rec_start_s = 1;
    tick(); rec_start_s = 0;
    check("s_rec_state", state_s, 2'd1);
    for (int i = 1; i <= 10; i++) begin
      bus_s.in_valid = 1; bus_s.in_data = 8'(i);
      tick();
      check($sformatf("s_rec%0d", i), {state_s, length_s, full_s},
            {(i < 8) ? 2'd1 : 2'd0, (i < 8) ? 4'(i) : 4'd8, i >= 8});
    end
    bus_s.in_valid = 0;
    play_start_s = 1; loop_s = 0; bus_s.out_ready = 1;
    tick(); play_start_s = 0;
    check("s_play_first", bus_s.out_valid, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("s_play%0d", i), {bus_s.out_valid, bus_s.out_data}, {1'b1, 8'(i)});
    end
    tick();
    check("s_play_end", {state_s, bus_s.out_valid}, {2'd0, 1'b0});
    play_start_s = 1;
    tick(); play_start_s = 0;
    tick(); tick();
    check("s_replay", {bus_s.out_valid, bus_s.out_data}, {1'b1, 8'd2});
    #2 rst_s = 1'b0;
    #1;
    check("s_mid_reset", {state_s, bus_s.out_valid, length_s, full_s}, 64'd0);
    @(posedge clk); #1;
    rst_s = 1'b1;
    play_start_s = 1;
    tick(); play_start_s = 0;
    tick();
    check("s_play_after_reset", {state_s, bus_s.out_valid}, {2'd0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sig_replay.md
Name: sig_replay

Overview:
- Record-then-playback sample buffer for the signal-generation lab datapath.
- RECORD: captures a burst of incoming samples (e.g. mic stream) into an internal dual-port RAM.
- PLAY: streams the captured burst back out, once or looped, over a valid/ready interface.
- Complements the delay line, which writes and reads at a fixed pointer offset; here write and read phases are separated and software/top-level controlled.

Parameters:
- A_WIDTH, 9, address width; buffer depth DEPTH = 2^A_WIDTH samples.
- D_WIDTH, 8, sample width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- rec_start  input  1  one-cycle pulse: begin a new recording.
- play_start  input  1  one-cycle pulse: begin playback of the stored burst.
- stop  input  1  abort the current record or play, return to IDLE.
- loop  input  1  sampled with play_start: 1 = wrap to sample 0 after the last sample.
- in_valid  input  1  in_data is a sample to record this cycle.
- in_data  input  D_WIDTH  sample to record.
- out_valid  output  1  out_data holds a playback sample.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  D_WIDTH  playback sample.
- length  output  A_WIDTH+1  number of samples stored, 0..DEPTH.
- full  output  1  length == DEPTH.
- state  output  2  00 IDLE, 01 RECORD, 10 PLAY.

Behaviour:
- Reset (rst=0, async): state=IDLE, length=0, full=0, out_valid=0, out_data=0, pointers=0, loop latch=0.
  - RAM contents are not cleared.
- IDLE
  - rec_start → RECORD; wr_ptr←0, length←0, full←0.
  - play_start with length>0 → PLAY; rd_ptr←0, loop latched.
  - play_start with length==0 is ignored.
  - rec_start and play_start together: rec_start wins.
- RECORD
  - Each cycle with in_valid=1: RAM[wr_ptr]←in_data, wr_ptr++, length++.
  - When the write raising length to DEPTH occurs → IDLE, full=1 on the same edge. Further in_valid is ignored.
  - stop → IDLE. A sample with in_valid=1 in the stop cycle is still written.
  - rec_start and play_start are ignored in RECORD.
- PLAY
  - RAM read has 1-cycle registered latency. The block prefetches so out_valid is first high in the second cycle after the play_start edge.
  - Holding out_ready=1 gives one sample per cycle with no bubbles, including across the loop wrap.
  - out_valid=1 and out_ready=0: out_data and out_valid hold stable. No sample is skipped or duplicated.
  - Transfer = out_valid & out_ready. Samples are emitted in order, index 0..length-1.
  - After the transfer of index length-1:
    - loop=0: → IDLE, out_valid=0 next cycle.
    - loop=1: continue with index 0.
  - stop → IDLE on that edge. out_valid=0 from the next cycle; a transfer in the stop cycle itself still counts.
  - rec_start and play_start are ignored in PLAY.
  - length and full are unchanged by playback.
- out_valid is 0 in IDLE and RECORD. out_data holds its last value when out_valid=0.
- Pointer arithmetic is modulo DEPTH. length is A_WIDTH+1 bits so DEPTH is representable.
- Reset asserted mid-operation: immediate return to reset values. A new recording is required before play (length=0).

Test Plan:
- Reset, then play_start → state stays 00, out_valid stays 0 for 10 cycles.
- rec_start; in_valid=1 for 5 cycles with data 10,20,30,40,50; stop → length=5, full=0, state=00.
- play_start, loop=0, out_ready=1 → out_valid rises 2 cycles after play_start; out_data 10,20,30,40,50 on consecutive cycles; then state=00, out_valid=0.
- Same play with out_ready toggling 1,0,0,1,… → each value held while ready=0; exactly 5 transfers in order.
- loop=1, out_ready=1 for 12 cycles → 10,20,30,40,50,10,20,… with no gap at the wrap; stop → out_valid=0 next cycle.
- A_WIDTH=3: record 10 samples 1..10 → length=8, full=1, auto-IDLE after the 8th write; play returns 1..8. Reset asserted mid-PLAY → out_valid=0 and length=0 immediately.
